store_rmw_ctrl: RTL and testbench

- Sequences sub-word stores (sb/sh) to the single-port, word-addressed data memory as read-modify-write, and issues sw directly.
- Sits between the store stage and the data memory.
- Owns the memory port for the duration of a store, performing the byte/half lane merge against the word read back.
- Rejects misaligned or illegal-size stores without touching memory.

---
 rtl/store_rmw_ctrl.sv | 114 +++++++++++
 tb/tb_store_rmw_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a single-port word memory: sw writes directly, sb/sh run read-capture-merge-write.
// Latency: sw done 1 cycle after accept; sb/sh done 3 cycles after accept; rejects flag err 1 cycle after accept.
// Backpressure: req_ready is high only when idle; the request is latched on accept so inputs need not be held.
//
// Ports: clk/rst (sync active-high), req_valid/req_ready/req_addr/req_data/req_size (store request),
//        done/err (one-cycle status pulses), mem_addr/mem_we/mem_wdata/mem_rdata (data memory port).
module store_rmw_ctrl #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state_q, state_d;
    logic [MEM_AW-1:0] waddr_q;
    logic [1:0]        boff_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [31:0]       old_q;

    logic              accept;
    logic              bad_req;
    logic [31:0]       merged;

    // Address bits above the memory range wrap; bit 1:0 only steer lanes.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    assign bad_req = (req_size == 2'b11)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad_req)                  state_d = S_ERR;
                    else if (req_size == SZ_WORD) state_d = S_WR;
                    else                          state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane merge: the store data replaces only the addressed byte/half of the word read back.
    always_comb begin
        merged = old_q;
        case (size_q)
            SZ_BYTE: merged[{boff_q, 3'b000} +: 8]       = data_q[7:0];
            SZ_HALF: merged[{boff_q[1], 4'b0000} +: 16]  = data_q[15:0];
            default: merged                              = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            waddr_q <= '0;
            boff_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                waddr_q <= req_addr[MEM_AW+1:2];
                boff_q  <= req_addr[1:0];
                data_q  <= req_data;
                size_q  <= req_size;
            end
            if (state_q == S_CAP) begin
                old_q <= mem_rdata;
            end
        end
    end

    // The latched word address is presented continuously; only RD and WR actually use it.
    assign mem_addr  = waddr_q;
    assign mem_we    = (state_q == S_WR);
    assign mem_wdata = (state_q == S_WR) ? merged : 32'h0;
    assign done      = (state_q == S_WR);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_store_rmw_ctrl.sv
module tb_store_rmw_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0]   mem     [0:(1<<AW)-1];
    logic [31:0]   ref_mem [0:(1<<AW)-1];

    logic          pl_init;
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_dat;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.MEM_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Synchronous-read memory; the bench preload port takes priority over the DUT write.
    always @(posedge clk) begin
        if (pl_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
        end else if (pl_we) begin
            mem[pl_addr] <= pl_dat;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: write the store's bytes into the addressed little-endian lanes.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] w;
        int lo;
        w  = old;
        lo = int'(a[1:0]);
        case (sz)
            2'b00: w[8*lo +: 8] = d[7:0];
            2'b01: begin
                w[8*lo +: 8]     = d[7:0];
                w[8*(lo+1) +: 8] = d[15:8];
            end
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic bit ref_illegal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01) return (a % 2) != 0;
        if (sz == 2'b10) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = AW'(idx);
        pl_dat  = val;
        @(negedge clk);
        pl_we   = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // Issue one store and observe cycles T+1..T+6 against the reference timing and data.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          done_cyc, err_cyc, we_cnt, rdy_cyc, both;
        bit          is_err, rd_ok;
        logic [31:0] exp_word, we_dat;
        logic [AW-1:0] idx, we_adr;
        idx      = a[AW+1:2];
        is_err   = ref_illegal(a, sz);
        exp_word = ref_merge(ref_mem[idx], a, d, sz);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom);
        done_cyc = 0; err_cyc = 0; we_cnt = 0; rdy_cyc = 0; both = 0;
        rd_ok = 1'b1; we_dat = '0; we_adr = '0;
        for (int c = 1; c <= 6; c++) begin
            if (done) done_cyc = (done_cyc == 0) ? c : 99;
            if (err)  err_cyc  = (err_cyc  == 0) ? c : 99;
            if (done && err) both++;
            if (mem_we) begin
                we_cnt++;
                we_dat = mem_wdata;
                we_adr = mem_addr;
            end
            if (req_ready && rdy_cyc == 0) rdy_cyc = c;
            if (c == 1 && !is_err && sz != 2'b10) rd_ok = !mem_we && (mem_addr == idx);
            if (c < 6) @(negedge clk);
        end
        check("done_cycle", done_cyc, is_err ? 0 : (sz == 2'b10 ? 1 : 3));
        check("err_cycle",  err_cyc,  is_err ? 1 : 0);
        check("we_count",   we_cnt,   is_err ? 0 : 1);
        check("ready_back", rdy_cyc,  (is_err || sz == 2'b10) ? 2 : 4);
        check("done_err_both", both, 0);
        if (!is_err) begin
            check("wdata", we_dat, exp_word);
            check("waddr", {22'b0, we_adr}, {22'b0, idx});
            if (sz != 2'b10) check("read_cycle", {31'b0, rd_ok}, 32'd1);
            ref_mem[idx] = exp_word;
        end
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int dn_cnt;
        logic rdy [1:7];
        logic dn  [1:7];
        logic [31:0] wd5;
        logic [31:0] a, d;
        logic [1:0]  sz;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        pl_init = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
        req_valid = 1'b1;                      // ignored while in reset
        @(negedge clk);
        pl_init = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_err",   {31'b0, err},       32'd0);
        check("rst_we",    {31'b0, mem_we},    32'd0);
        check("rst_addr",  {22'b0, mem_addr},  32'd0);
        check("rst_wdata", mem_wdata,          32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // sw direct
        preload(5, 32'hAAAAAAAA);
        do_store(32'h14, 32'h12345678, 2'b10);
        // sb sweep
        for (int k = 0; k < 4; k++) begin
            preload(2, 32'h11223344);
            do_store(32'h08 + k, 32'h000000EE, 2'b00);
        end
        // sh both halves
        preload(3, 32'hDEADBEEF);
        do_store(32'h0C, 32'h0000CAFE, 2'b01);
        preload(3, 32'hDEADBEEF);
        do_store(32'h0E, 32'h0000CAFE, 2'b01);
        // rejects
        do_store(32'h0D, 32'h0000BEEF, 2'b01);
        do_store(32'h12, 32'h01020304, 2'b10);
        do_store(32'h20, 32'h01020304, 2'b11);

        // Back-to-back: sb then sw with req_valid held high
        wait_ready();
        req_valid = 1'b1; req_addr = 32'h09; req_data = 32'h00000077; req_size = 2'b00;
        @(negedge clk);
        wd5 = '0;
        for (int c = 1; c <= 7; c++) begin
            rdy[c] = req_ready;
            dn[c]  = done;
            if (c == 5) wd5 = mem_wdata;
            if (c == 1) begin
                req_addr = 32'h30; req_data = 32'hCAFEF00D; req_size = 2'b10;
            end
            if (c == 5) req_valid = 1'b0;
            if (c < 7) @(negedge clk);
        end
        dn_cnt = 0;
        for (int c = 1; c <= 7; c++) if (dn[c]) dn_cnt++;
        check("b2b_rdy1", {31'b0, rdy[1]}, 32'd0);
        check("b2b_rdy3", {31'b0, rdy[3]}, 32'd0);
        check("b2b_rdy4", {31'b0, rdy[4]}, 32'd1);
        check("b2b_done3", {31'b0, dn[3]}, 32'd1);
        check("b2b_done5", {31'b0, dn[5]}, 32'd1);
        check("b2b_done_cnt", dn_cnt, 2);
        check("b2b_wdata", wd5, 32'hCAFEF00D);
        ref_mem[2]  = ref_merge(ref_mem[2], 32'h09, 32'h77, 2'b00);
        ref_mem[12] = 32'hCAFEF00D;
        check("b2b_mem2",  mem[2],  ref_mem[2]);
        check("b2b_mem12", mem[12], ref_mem[12]);

        // Reset while in CAP abandons the store
        preload(2, 32'h11223344);
        wait_ready();
        req_valid = 1'b1; req_addr = 32'h08; req_data = 32'h00000055; req_size = 2'b00;
        @(negedge clk);                         // RD
        req_valid = 1'b0;
        @(negedge clk);                         // CAP
        rst = 1'b1;
        @(negedge clk);
        check("rstcap_ready", {31'b0, req_ready}, 32'd1);
        check("rstcap_we",    {31'b0, mem_we},    32'd0);
        check("rstcap_done",  {31'b0, done},      32'd0);
        rst = 1'b0;
        dn_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || err || mem_we) dn_cnt++;
        end
        check("rstcap_quiet", dn_cnt, 0);
        check("rstcap_mem2", mem[2], 32'h11223344);
        do_store(32'h14, 32'h0BADF00D, 2'b10);

        // Randomized stores, concentrated on a few words, upper address bits random
        for (int n = 0; n < 200; n++) begin
            a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_store(a, d, sz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
